// File: rtl/ov7670_capture.sv
// OV7670 camera bus capture: pairs bytes into RGB565 words and strobes them into the line cache.
// Optional build macro CAP_TESTPAT_EN adds a TESTPAT input that substitutes 8 vertical colour bars.

module ov7670_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        CAPTURE_EN,
  input  logic        CAM_PCLK,
  input  logic        CAM_HREF,
  input  logic        CAM_VSYNC,
  input  logic [7:0]  CAM_DATA,
  input  logic        CACHE_WR_EN,
`ifdef CAP_TESTPAT_EN
  input  logic        TESTPAT,
`endif
  output logic [15:0] PIX_DATA,
  output logic        PIX_WREQ,
  output logic [10:0] PIX_X,
  output logic [10:0] PIX_Y,
  output logic        FRAME_START,
  output logic        LINE_END,
  output logic        FRAME_DONE,
  output logic        CACHE_OVF
);

  localparam int          SKW   = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [10:0] H_MAX = 11'(H_PIXELS);
  localparam logic [10:0] V_MAX = 11'(V_LINES);

  // state  | meaning
  // IDLE   | capture stopped
  // SKIP   | discarding start-up frames, counting VSYNC rises
  // ARM    | waiting for VSYNC fall to begin a frame
  // ACTIVE | capturing a frame
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ARM, S_ACTIVE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     pclk_sync_q, pclk_sync_d;
  logic [2:0]     href_sync_q, href_sync_d;
  logic [2:0]     vsync_sync_q, vsync_sync_d;
  logic [7:0]     data_s1_q, data_s1_d;
  logic [7:0]     data_s2_q, data_s2_d;
  logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
  logic           phase_q, phase_d;
  logic [7:0]     hi_byte_q, hi_byte_d;
  logic           done_pend_q, done_pend_d;
  logic [15:0]    pix_data_q, pix_data_d;
  logic           pix_wreq_q, pix_wreq_d;
  logic [10:0]    pix_x_q, pix_x_d;
  logic [10:0]    pix_y_q, pix_y_d;
  logic           frame_start_q, frame_start_d;
  logic           line_end_q, line_end_d;
  logic           frame_done_q, frame_done_d;
  logic           cache_ovf_q, cache_ovf_d;

  logic        pclk_rise, href_lvl, href_fall, vs_rise, vs_fall, line_close;
  logic [15:0] word;

  always_comb begin
    pclk_sync_d  = {pclk_sync_q[1:0], CAM_PCLK};
    href_sync_d  = {href_sync_q[1:0], CAM_HREF};
    vsync_sync_d = {vsync_sync_q[1:0], CAM_VSYNC};
    data_s1_d    = CAM_DATA;
    data_s2_d    = data_s1_q;
  end

  assign pclk_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
  assign href_lvl  = href_sync_q[1];
  assign href_fall = ~href_sync_q[1] & href_sync_q[2];
  assign vs_rise   = vsync_sync_q[1] & ~vsync_sync_q[2];
  assign vs_fall   = ~vsync_sync_q[1] & vsync_sync_q[2];

  // A VSYNC rise during an open line closes the line first; FRAME_DONE follows next cycle.
  assign line_close = (state_q == S_ACTIVE) && !done_pend_q &&
                      (href_fall || (vs_rise && href_lvl));

`ifdef CAP_TESTPAT_EN
  function automatic logic [15:0] bar_color(input logic [10:0] x);
    logic [10:0] idx;
    idx = x / 11'd80;
    case (idx)
      11'd0:   bar_color = 16'hFFFF;
      11'd1:   bar_color = 16'hFFE0;
      11'd2:   bar_color = 16'h07FF;
      11'd3:   bar_color = 16'h07E0;
      11'd4:   bar_color = 16'hF81F;
      11'd5:   bar_color = 16'hF800;
      11'd6:   bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  assign word = TESTPAT ? bar_color(pix_x_q) : {hi_byte_q, data_s2_q};
`else
  assign word = {hi_byte_q, data_s2_q};
`endif

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    done_pend_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_wreq_d    = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;
    frame_done_d  = 1'b0;
    cache_ovf_d   = cache_ovf_q | (pix_wreq_q & ~CACHE_WR_EN);

    if (pix_wreq_q && (pix_x_q < H_MAX)) pix_x_d = pix_x_q + 11'd1;

    case (state_q)
      S_IDLE: begin
        if (CAPTURE_EN) begin
          skip_cnt_d = SKW'(SKIP_FRAMES);
          state_d    = (SKIP_FRAMES > 0) ? S_SKIP : S_ARM;
        end
      end
      S_SKIP: begin
        if (!CAPTURE_EN) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          skip_cnt_d = skip_cnt_q - SKW'(1);
          if (skip_cnt_q == SKW'(1)) state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!CAPTURE_EN) begin
          state_d = S_IDLE;
        end else if (vs_fall) begin
          frame_start_d = 1'b1;
          pix_x_d       = '0;
          pix_y_d       = '0;
          phase_d       = 1'b0;
          cache_ovf_d   = 1'b0;
          state_d       = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (done_pend_q || (vs_rise && !line_close)) begin
          frame_done_d = 1'b1;
          state_d      = CAPTURE_EN ? S_ARM : S_IDLE;
        end else if (vs_rise) begin
          done_pend_d = 1'b1;
        end else if (pclk_rise && href_lvl) begin
          if (!phase_q) begin
            hi_byte_d = data_s2_q;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((pix_x_q < H_MAX) && (pix_y_q < V_MAX)) begin
              pix_wreq_d = 1'b1;
              pix_data_d = word;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (line_close) begin
      phase_d    = 1'b0;
      pix_x_d    = '0;
      line_end_d = 1'b1;
      if (pix_y_q < V_MAX) pix_y_d = pix_y_q + 11'd1;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      pclk_sync_q   <= '0;
      href_sync_q   <= '0;
      vsync_sync_q  <= '0;
      data_s1_q     <= '0;
      data_s2_q     <= '0;
      skip_cnt_q    <= '0;
      phase_q       <= 1'b0;
      hi_byte_q     <= '0;
      done_pend_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_wreq_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      cache_ovf_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pclk_sync_q   <= pclk_sync_d;
      href_sync_q   <= href_sync_d;
      vsync_sync_q  <= vsync_sync_d;
      data_s1_q     <= data_s1_d;
      data_s2_q     <= data_s2_d;
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      done_pend_q   <= done_pend_d;
      pix_data_q    <= pix_data_d;
      pix_wreq_q    <= pix_wreq_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      frame_done_q  <= frame_done_d;
      cache_ovf_q   <= cache_ovf_d;
    end
  end

  assign PIX_DATA    = pix_data_q;
  assign PIX_WREQ    = pix_wreq_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign FRAME_START = frame_start_q;
  assign LINE_END    = line_end_q;
  assign FRAME_DONE  = frame_done_q;
  assign CACHE_OVF   = cache_ovf_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: random camera frames, expected words queued per line.

module tb_ov7670_capture;

  localparam int H    = 640;
  localparam int V    = 4;
  localparam int SKIP = 2;

  logic        SYS_CLK = 1'b0;
  logic        RST, CAPTURE_EN, CAM_PCLK, CAM_HREF, CAM_VSYNC, CACHE_WR_EN;
  logic [7:0]  CAM_DATA;
  logic [15:0] PIX_DATA;
  logic        PIX_WREQ, FRAME_START, LINE_END, FRAME_DONE, CACHE_OVF;
  logic [10:0] PIX_X, PIX_Y;

  always #5 SYS_CLK = ~SYS_CLK;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIP)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .CAPTURE_EN(CAPTURE_EN),
    .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF), .CAM_VSYNC(CAM_VSYNC),
    .CAM_DATA(CAM_DATA), .CACHE_WR_EN(CACHE_WR_EN),
    .PIX_DATA(PIX_DATA), .PIX_WREQ(PIX_WREQ), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .FRAME_START(FRAME_START), .LINE_END(LINE_END), .FRAME_DONE(FRAME_DONE),
    .CACHE_OVF(CACHE_OVF)
  );

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int  n_checks = 0, n_pass = 0;
  int  cyc = 0, fs_cnt = 0, le_cnt = 0, fd_cnt = 0, le_cyc = 0, fd_cyc = 0;
  int  rs_fs, rs_le, rs_fd;
  int  ends_seen = 0;
  bit  en = 0, frame_cap = 0, rst_hit = 0, exp_ovf = 0, force_pair = 0;
  time last_rise_t = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                  name, act, act, req, req, $time);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Monitor: pops one expected word per strobe cycle and tallies pulses.
  always @(negedge SYS_CLK) begin
    cyc++;
    if (PIX_WREQ) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wreq", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_data", int'(PIX_DATA), int'(mon_e.d));
        check("pix_x", int'(PIX_X), mon_e.x);
        check("pix_y", int'(PIX_Y), mon_e.y);
        check("wreq_latency", int'(($time - last_rise_t) / 10), 3);
      end
    end
    if (FRAME_START) fs_cnt++;
    if (LINE_END) begin le_cnt++; le_cyc = cyc; end
    if (FRAME_DONE) begin fd_cnt++; fd_cyc = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge SYS_CLK);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int h;
    h = $urandom_range(2, 3);
    CAM_DATA = b;
    step(h);
    CAM_PCLK = 1'b1;
    last_rise_t = $time;
    step(h);
    CAM_PCLK = 1'b0;
  endtask

  task automatic apply_mid_reset();
    step(3);
    check("pre_reset_drain", exp_q.size(), 0);
    RST = 1'b1;
    step(1);
    check("reset_outputs_nonzero_bits",
          $countones({PIX_DATA, PIX_WREQ, PIX_X, PIX_Y, FRAME_START, LINE_END, FRAME_DONE, CACHE_OVF}), 0);
    RST = 1'b0;
    frame_cap = 0;
    ends_seen = 0;
    rst_hit   = 1;
    rs_fs = fs_cnt; rs_le = le_cnt; rs_fd = fd_cnt;
  endtask

  // Reference: word i of line y is bytes {2i, 2i+1}; kept while i < H and y < V.
  task automatic send_line(input int nb, input int y, input int ovf_word,
                           input int rst_after, input bit no_close);
    logic [7:0] bytes[$];
    int words;
    for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
    if (force_pair) begin bytes[0] = 8'hF8; bytes[1] = 8'h1F; force_pair = 0; end
    words = ((rst_after >= 0) ? rst_after : nb) / 2;
    if (frame_cap && y < V) begin
      for (int i = 0; i < imin(words, H); i++) begin
        exp_t e;
        e.d = {bytes[2*i], bytes[2*i+1]};
        e.x = i;
        e.y = y;
        exp_q.push_back(e);
      end
      if (ovf_word >= 0 && ovf_word < imin(words, H)) exp_ovf = 1;
    end
    CAM_HREF = 1'b1;
    step(2);
    for (int i = 0; i < nb; i++) begin
      if (ovf_word >= 0 && i == 2*ovf_word) begin step(4); CACHE_WR_EN = 1'b0; end
      send_byte(bytes[i]);
      if (ovf_word >= 0 && i == 2*ovf_word + 1) begin step(5); CACHE_WR_EN = 1'b1; end
      if (i + 1 == rst_after) apply_mid_reset();
    end
    step(2);
    if (frame_cap) check("pix_x_end_of_line", int'(PIX_X), (y < V) ? imin(nb / 2, H) : 0);
    if (!no_close) begin
      CAM_HREF = 1'b0;
      step(4);
      if (frame_cap) begin
        check("pix_x_after_line", int'(PIX_X), 0);
        check("pix_y_after_line", int'(PIX_Y), imin(y + 1, V));
      end
    end
  endtask

  task automatic send_frame(input int nlines, input int first_nb, input int long_line,
                            input int ovf_line, input int stop_line, input int rst_line,
                            input bit vs_href);
    bit cap;
    int fs0, le0, fd0, nb;
    cap = en && (ends_seen >= SKIP);
    frame_cap = cap;
    rst_hit = 0;
    exp_ovf = 0;
    fs0 = fs_cnt; le0 = le_cnt; fd0 = fd_cnt;
    CAM_VSYNC = 1'b0;
    step(6);
    if (cap) check("pix_y_at_frame_start", int'(PIX_Y), 0);
    for (int l = 0; l < nlines; l++) begin
      nb = $urandom_range(1, 40);
      if (l == 0 && first_nb > 0) nb = first_nb;
      if (l == long_line) nb = 1300;
      if (l == ovf_line || l == rst_line) nb = (nb < 12) ? 12 : nb;
      send_line(nb, l, (l == ovf_line) ? 4 : -1, (l == rst_line) ? 5 : -1,
                vs_href && (l == nlines - 1));
      step(3);
      if (l == stop_line) begin en = 0; CAPTURE_EN = 1'b0; end
    end
    CAM_VSYNC = 1'b1;
    step(6);
    if (vs_href) begin CAM_HREF = 1'b0; step(4); end
    if (rst_hit) begin
      check("frame_start_after_reset", fs_cnt - rs_fs, 0);
      check("line_end_after_reset", le_cnt - rs_le, 0);
      check("frame_done_after_reset", fd_cnt - rs_fd, 0);
    end else begin
      check("frame_start_count", fs_cnt - fs0, cap ? 1 : 0);
      check("line_end_count", le_cnt - le0, cap ? nlines : 0);
      check("frame_done_count", fd_cnt - fd0, cap ? 1 : 0);
      if (cap) check("cache_ovf_at_frame_end", int'(CACHE_OVF), int'(exp_ovf));
      if (cap && vs_href) check("line_end_then_frame_done", fd_cyc - le_cyc, 1);
    end
    if (!en) ends_seen = 0;
    else if (!frame_cap) ends_seen++;
    step(4);
  endtask

  task automatic set_en(input bit v);
    en = v;
    CAPTURE_EN = v;
    ends_seen = 0;
    step(4);
  endtask

  initial begin
    RST = 1'b1; CAPTURE_EN = 1'b0; CAM_PCLK = 1'b0; CAM_HREF = 1'b0;
    CAM_VSYNC = 1'b1; CAM_DATA = 8'h00; CACHE_WR_EN = 1'b1;
    step(3);
    check("reset_outputs_nonzero_bits",
          $countones({PIX_DATA, PIX_WREQ, PIX_X, PIX_Y, FRAME_START, LINE_END, FRAME_DONE, CACHE_OVF}), 0);
    RST = 1'b0;
    step(10);

    set_en(1);
    send_frame(2, -1, -1, -1, -1, -1, 0);   // skipped
    send_frame(2, -1, -1, -1, -1, -1, 0);   // skipped
    force_pair = 1;
    send_frame(3, 2, -1, -1, -1, -1, 0);    // first captured frame, F8/1F pairing
    send_frame(6, -1, -1, 1, -1, -1, 0);    // overrun on word 4, lines beyond V
    send_frame(2, -1, 0, -1, -1, -1, 0);    // 650-word line, overrun flag cleared
    send_frame(3, 3, -1, -1, -1, -1, 0);    // odd byte dangling on line 0
    send_frame(3, -1, -1, -1, -1, -1, 1);   // VSYNC rises while HREF high
    send_frame(3, -1, -1, -1, 1, -1, 0);    // CAPTURE_EN dropped mid-frame
    send_frame(2, -1, -1, -1, -1, -1, 0);   // idle, nothing captured

    set_en(1);
    send_frame(2, -1, -1, -1, -1, -1, 0);
    send_frame(2, -1, -1, -1, -1, -1, 0);
    send_frame(3, -1, -1, -1, -1, -1, 0);
    send_frame(3, -1, -1, -1, -1, 1, 0);    // reset in the middle of line 1
    send_frame(2, -1, -1, -1, -1, -1, 0);   // second skip after reset
    for (int f = 0; f < 3; f++)
      send_frame($urandom_range(1, 6), -1, -1, ($urandom_range(0, 1) == 1) ? 0 : -1, -1, -1, 0);

    step(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
